// File: rtl/grant_dispatcher_pkg.sv
// rtl/grant_dispatcher_pkg.sv - shared constants, state enum and helpers for the grant dispatcher
package rr_dispatch_pkg;

    localparam int N_REQ      = 4;
    localparam int IDX_W      = 2;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        ACK  = 2'd2
    } disp_state_t;

    // One-hot pattern that a well-formed grant for requester idx must match
    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        idx_to_onehot      = '0;
        idx_to_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/grant_dispatcher_if.sv
// rtl/grant_dispatcher_if.sv - arbiter-side and output-channel signals of the grant dispatcher
interface grant_dispatcher_if
    import rr_dispatch_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic [N_REQ-1:0]        grant_vector;
    logic [IDX_W-1:0]        index;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic                    arb_enable;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_data;
    logic [IDX_W-1:0]        out_src;
    logic [N_REQ-1:0]        ack;

    // The dispatcher itself
    modport master (
        input  grant_vector, index, req_data, out_ready,
        output arb_enable, out_valid, out_data, out_src, ack
    );

    // Arbiter, requesters and downstream consumer
    modport slave (
        output grant_vector, index, req_data, out_ready,
        input  arb_enable, out_valid, out_data, out_src, ack
    );

endinterface

// File: rtl/grant_dispatcher_stats_counter.sv
// rtl/grant_dispatcher_stats_counter.sv - saturating clearable per-requester counters (present only with GRANT_STATS_EN)
`ifdef GRANT_STATS_EN
module grant_stats_counter
    import rr_dispatch_pkg::*;
#(
    parameter int N     = N_REQ,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [N-1:0]     inc,
    output logic [N*CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q [N];

    // Counter bank: clear beats increment, each counter sticks at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (inc[i] && (cnt_q[i] != {CNT_W{1'b1}})) cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign count[g*CNT_W +: CNT_W] = cnt_q[g];
    end

endmodule
`endif

// File: rtl/grant_dispatcher.sv
// rtl/grant_dispatcher.sv - captures one arbiter grant at a time, forwards its payload, acks the winner; GRANT_STATS_EN adds transfer counters
module grant_dispatcher
    import rr_dispatch_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    grant_dispatcher_if.master      bus,
    output logic                    err,
    input  logic                    stats_clr,
    output logic [N_REQ*CNT_W-1:0]  grant_count
);

    disp_state_t       state, state_nxt;
    logic              capture;
    logic              proto_err;
    logic              arb_en_w;
    logic              out_valid_w;
    logic [N_REQ-1:0]  ack_w;
    logic              grant_any;
    logic              grant_ok;
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] out_data_q;
    logic [IDX_W-1:0]  out_src_q;

    assign grant_any = |bus.grant_vector;
    assign grant_ok  = (bus.grant_vector == idx_to_onehot(bus.index));

    // Payload of the requester named by index
    always_comb begin
        sel_data = bus.req_data[bus.index*DATA_W +: DATA_W];
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and all handshake outputs; outputs decode from state so reset clears them at once
    always_comb begin
        state_nxt   = state;
        capture     = 1'b0;
        proto_err   = 1'b0;
        arb_en_w    = 1'b0;
        out_valid_w = 1'b0;
        ack_w       = '0;
        case (state)
            IDLE: begin
                arb_en_w = 1'b1;
                if (grant_any) begin
                    if (grant_ok) begin
                        capture   = 1'b1;
                        state_nxt = SEND;
                    end else begin
                        proto_err = 1'b1;
                    end
                end
            end
            SEND: begin
                out_valid_w = 1'b1;
                if (bus.out_ready) state_nxt = ACK;
            end
            ACK: begin
                ack_w     = idx_to_onehot(out_src_q);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Payload and owner held from capture until the next capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data_q <= '0;
            out_src_q  <= '0;
        end else if (capture) begin
            out_data_q <= sel_data;
            out_src_q  <= bus.index;
        end
    end

    // Sticky flag for malformed grants seen while idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         err <= 1'b0;
        else if (proto_err) err <= 1'b1;
    end

    assign bus.arb_enable = arb_en_w;
    assign bus.out_valid  = out_valid_w;
    assign bus.out_data   = out_data_q;
    assign bus.out_src    = out_src_q;
    assign bus.ack        = ack_w;

`ifdef GRANT_STATS_EN
    grant_stats_counter #(
        .N     (N_REQ),
        .CNT_W (CNT_W)
    ) u_stats (
        .clk   (clk),
        .reset (reset),
        .clr   (stats_clr),
        .inc   (ack_w),
        .count (grant_count)
    );
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr;
    assign grant_count      = '0;
`endif

endmodule

// File: tb/tb_grant_dispatcher.sv
// tb/tb_grant_dispatcher.sv - self-checking bench for grant_dispatcher with a payload scoreboard
module tb_grant_dispatcher;
    import rr_dispatch_pkg::*;

    localparam int DW = 8;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            stats_clr = 1'b0;
    logic            err;
    logic [4*CW-1:0] grant_count;

    int checks = 0;
    int passed = 0;
    logic [DW+1:0] exp_q [$];

    grant_dispatcher_if #(.DATA_W(DW)) bus ();

    grant_dispatcher #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .err         (err),
        .stats_clr   (stats_clr),
        .grant_count (grant_count)
    );

    always #5 clk = ~clk;

    task automatic xfer(input logic [1:0] idx, input logic [7:0] d, input int stall);
        logic [DW+1:0] got;
        logic [DW+1:0] want;
        logic [3:0]    oh;
        bit            seen;
        oh = 4'b0001 << idx;
        bus.req_data = $urandom;
        bus.req_data[idx*DW +: DW] = d;
        bus.grant_vector = oh;
        bus.index = idx;
        bus.out_ready = 1'b0;
        exp_q.push_back({idx, d});
        @(negedge clk);
        bus.grant_vector = 4'b0000;
        bus.req_data = $urandom;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.arb_enable !== 1'b0)
            $display("FAIL xfer_send_entry: out_valid=%b arb_enable=%b, want 1 0", bus.out_valid, bus.arb_enable);
        else passed++;
        for (int k = 0; k < stall; k++) begin
            bus.grant_vector = 4'b1001;
            bus.index = 2'd0;
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.arb_enable !== 1'b0 || bus.ack !== 4'b0 || bus.out_data !== d)
                $display("FAIL xfer_stall: valid=%b en=%b ack=%b data=%h, want 1 0 0000 %h",
                         bus.out_valid, bus.arb_enable, bus.ack, bus.out_data, d);
            else passed++;
        end
        bus.grant_vector = 4'b0000;
        bus.out_ready = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            if (bus.out_valid === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin
            $display("FAIL xfer_handshake_timeout: out_valid never seen, want 1");
        end else if (exp_q.size() == 0) begin
            $display("FAIL xfer_scoreboard_empty: got %h, want nothing", {bus.out_src, bus.out_data});
        end else begin
            want = exp_q.pop_front();
            got = {bus.out_src, bus.out_data};
            if (got !== want) $display("FAIL xfer_payload: src/data=%h, want %h", got, want);
            else passed++;
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.ack !== oh || bus.out_valid !== 1'b0 || bus.arb_enable !== 1'b0)
            $display("FAIL xfer_ack: ack=%b valid=%b en=%b, want %b 0 0", bus.ack, bus.out_valid, bus.arb_enable, oh);
        else passed++;
        @(negedge clk);
        checks++;
        if (bus.ack !== 4'b0 || bus.arb_enable !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL xfer_idle_return: ack=%b en=%b valid=%b, want 0000 1 0", bus.ack, bus.arb_enable, bus.out_valid);
        else passed++;
    endtask

    task automatic test_reset();
        bus.grant_vector = 4'b0;
        bus.index = 2'd0;
        bus.req_data = '0;
        bus.out_ready = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.arb_enable !== 1'b1 || bus.out_valid !== 1'b0 || bus.ack !== 4'b0)
            $display("FAIL reset_ctrl: en=%b valid=%b ack=%b, want 1 0 0000", bus.arb_enable, bus.out_valid, bus.ack);
        else passed++;
        checks++;
        if (bus.out_data !== 8'h00 || bus.out_src !== 2'd0 || err !== 1'b0 || grant_count !== '0)
            $display("FAIL reset_data: data=%h src=%0d err=%b cnt=%h, want 0 0 0 0",
                     bus.out_data, bus.out_src, err, grant_count);
        else passed++;
        reset = 1'b1;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.arb_enable !== 1'b1 || bus.out_valid !== 1'b0 || bus.ack !== 4'b0)
                $display("FAIL idle_cycle%0d: en=%b valid=%b ack=%b, want 1 0 0000", i, bus.arb_enable, bus.out_valid, bus.ack);
            else passed++;
        end
    endtask

    task automatic test_single();
        xfer(2'd1, 8'hA5, 0);
        checks++;
        if (err !== 1'b0) $display("FAIL single_err: err=%b, want 0", err);
        else passed++;
    endtask

    task automatic test_backpressure();
        xfer(2'd2, 8'h3C, 4);
        checks++;
        if (err !== 1'b0) $display("FAIL backpressure_err: err=%b, want 0 (grant ignored outside IDLE)", err);
        else passed++;
    endtask

    task automatic test_back_to_back_stats();
        logic [4*CW-1:0] want;
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        checks++;
        if (grant_count !== '0) $display("FAIL stats_pre_clear: cnt=%h, want 0", grant_count);
        else passed++;
        xfer(2'd0, 8'h11, 0);
        xfer(2'd0, 8'h22, 0);
        xfer(2'd3, 8'hE7, 1);
        xfer(2'd0, 8'h33, 0);
`ifdef GRANT_STATS_EN
        want = {16'd1, 16'd0, 16'd0, 16'd3};
`else
        want = '0;
`endif
        checks++;
        if (grant_count !== want) $display("FAIL stats_counts: cnt=%h, want %h", grant_count, want);
        else passed++;
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        checks++;
        if (grant_count !== '0) $display("FAIL stats_clear: cnt=%h, want 0", grant_count);
        else passed++;
    endtask

    task automatic test_reset_mid_send();
        bus.req_data = {4{8'h77}};
        bus.grant_vector = 4'b0001;
        bus.index = 2'd0;
        @(negedge clk);
        bus.grant_vector = 4'b0;
        checks++;
        if (bus.out_valid !== 1'b1) $display("FAIL rst_send_entry: valid=%b, want 1", bus.out_valid);
        else passed++;
        #1 reset = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.arb_enable !== 1'b1 || bus.out_data !== 8'h00 || bus.out_src !== 2'd0 || bus.ack !== 4'b0)
            $display("FAIL rst_async: valid=%b en=%b data=%h src=%0d ack=%b, want 0 1 00 0 0000",
                     bus.out_valid, bus.arb_enable, bus.out_data, bus.out_src, bus.ack);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.ack !== 4'b0 || bus.out_valid !== 1'b0)
                $display("FAIL rst_no_ack%0d: ack=%b valid=%b, want 0000 0", i, bus.ack, bus.out_valid);
            else passed++;
        end
        checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: %0d entries, want 0", exp_q.size());
        else passed++;
    endtask

    task automatic test_protocol_error();
        bus.grant_vector = 4'b0110;
        bus.index = 2'd1;
        @(negedge clk);
        bus.grant_vector = 4'b0;
        checks++;
        if (err !== 1'b1 || bus.out_valid !== 1'b0 || bus.arb_enable !== 1'b1)
            $display("FAIL perr_multihot: err=%b valid=%b en=%b, want 1 0 1", err, bus.out_valid, bus.arb_enable);
        else passed++;
        repeat (2) @(negedge clk);
        checks++;
        if (err !== 1'b1 || bus.out_valid !== 1'b0) $display("FAIL perr_sticky: err=%b valid=%b, want 1 0", err, bus.out_valid);
        else passed++;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if (err !== 1'b0) $display("FAIL perr_reset_clear: err=%b, want 0", err);
        else passed++;
        bus.grant_vector = 4'b0001;
        bus.index = 2'd3;
        @(negedge clk);
        bus.grant_vector = 4'b0;
        checks++;
        if (err !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL perr_index_mismatch: err=%b valid=%b, want 1 0", err, bus.out_valid);
        else passed++;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.ack !== 4'b0)
            $display("FAIL perr_no_capture: valid=%b ack=%b, want 0 0000", bus.out_valid, bus.ack);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_backpressure();
        test_back_to_back_stats();
        test_reset_mid_send();
        test_protocol_error();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/grant_dispatcher.md
# grant_dispatcher

Downstream stage of the 4-requester round-robin arbiter. Consumes the arbiter's registered one-hot `grant_vector` and binary `index` and captures the granted requester's payload. It forwards that payload over a single valid/ready output channel and returns a one-cycle acknowledge to the winning requester. It throttles the arbiter through its `enable` input so that only one grant is in flight at a time.

## Interface

Parameters:
- DATA_W, 8, payload width per requester
- CNT_W, 16, width of each per-requester transfer counter (used only with GRANT_STATS_EN)

Ports. One clock; reset is asynchronous and active-low.
- clk, input, 1, rising-edge clock
- reset, input, 1, asynchronous, active-low reset
- grant_vector, input, 4, one-hot grant from the arbiter; 0 when no grant
- index, input, 2, binary index of the granted requester
- req_data, input, 4*DATA_W, payloads; requester i occupies bits [i*DATA_W +: DATA_W]
- arb_enable, output, 1, drives the arbiter's `enable`
- out_valid, output, 1, output payload valid
- out_ready, input, 1, downstream accepts the payload
- out_data, output, DATA_W, captured payload
- out_src, output, 2, index of the requester that owns `out_data`
- ack, output, 4, one-hot, one-cycle pulse to the served requester
- err, output, 1, sticky protocol-error flag
- stats_clr, input, 1, synchronous clear of all counters
- grant_count, output, 4*CNT_W, per-requester completed-transfer counts

## Operation

- FSM states (in shared enum): IDLE, SEND, ACK.
- IDLE:
  - arb_enable=1, out_valid=0, ack=0.
  - If grant_vector==0: remain in IDLE.
  - If grant_vector == (4'b1 << index): capture req_data[index] into out_data and index into out_src, then go to SEND.
  - Any other nonzero grant_vector (multi-hot, or inconsistent with index): ignore it, set err=1, remain in IDLE.
- SEND:
  - arb_enable=0, out_valid=1.
  - out_data and out_src stay stable until the handshake.
  - On out_valid & out_ready: go to ACK.
- ACK:
  - ack[out_src]=1 for exactly this cycle; out_valid=0, arb_enable=0.
  - Go to IDLE.
- grant_vector and index are ignored in SEND and ACK. Any stale grant held by the arbiter's output register is never acted on.
- err clears only on reset.

## Timing

- Reset values:
  - State IDLE, so arb_enable=1.
  - out_valid=0, out_data=0, out_src=0, ack=0, err=0, grant_count=0.
- Latency from grant to output: a valid grant sampled in IDLE at cycle N gives out_valid=1 at cycle N+1.
- arb_enable drops in cycle N+1. The arbiter's registered output is therefore 0 from N+2 onward.
- Handshake at cycle M (out_valid & out_ready) gives ack pulse at M+1 and IDLE at M+2. The earliest next capture is at M+2, using a grant the arbiter registered while enabled.
- Minimum spacing between transfers is 3 cycles when out_ready is held high.
- Reset asserted mid-SEND or mid-ACK: all outputs return to their reset values immediately (asynchronously). The in-flight payload is dropped and no ack is issued.

## Configuration

- Macro: GRANT_STATS_EN.
- Defined:
  - grant_count[i] increments on the ACK cycle for requester i.
  - Counters saturate at all-ones.
  - stats_clr zeroes all counters; if stats_clr coincides with an increment, the clear wins.
- Not defined: grant_count is tied to 0 and stats_clr is ignored. Port list is identical in both builds.

## Structure

- Package rr_dispatch_pkg holds:
  - N_REQ=4, IDX_W=2
  - state enum (IDLE, SEND, ACK)
  - the default DATA_W and CNT_W constants
- One sub-module, grant_stats_counter. It is the saturating, clearable counter bank (N_REQ x CNT_W) and is instantiated only under GRANT_STATS_EN.

## Test plan

- Reset then idle: grant_vector=0000 held for 5 cycles -> arb_enable=1, out_valid=0, ack=0000 throughout.
- Single grant: grant_vector=0010, index=01, req_data[1]=8'hA5, out_ready=1 -> out_valid with out_data=A5, out_src=01 one cycle later; ack=0010 for one cycle; back in IDLE 3 cycles after capture.
- Backpressure: grant_vector=0100, index=10, req_data[2]=8'h3C, out_ready=0 for 4 cycles then 1 -> out_data=3C stable and arb_enable=0 throughout; ack=0100 the cycle after out_ready rises.
- Protocol error: grant_vector=0110 or (0001 with index=11) in IDLE -> err=1 sticky, no capture, out_valid=0.
- Reset mid-SEND: assert reset while out_valid=1 -> out_valid=0 and arb_enable=1 immediately; no ack pulse after release.
- With GRANT_STATS_EN: 3 transfers for requester 0 and 1 for requester 3 -> grant_count[0]=3, grant_count[3]=1; then stats_clr -> all counts 0. Without the macro -> grant_count stays 0.
